load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, data path width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request strobe.
REQ-006 SHALL have port op  input  3  op[1:0] size (0 byte, 1 half, 2 word, 3 double); op[2]=1 zero-extend load.
REQ-007 SHALL have port writeEnable  input  1  1 store, 0 load.
REQ-008 SHALL have ports base  input  ADDR_WIDTH  register operand; imm  input  16  signed offset.
REQ-009 SHALL have port storeData  input  BUS_WIDTH  store operand, right-aligned.
REQ-010 SHALL have ports busy, done, error  output  1 each  FSM not IDLE; completion pulse; fault pulse.
REQ-011 SHALL have port loadData  output  BUS_WIDTH  extended load result, valid while done=1.
REQ-012 SHALL have memory-side ports memAddr  output  ADDR_WIDTH; memRequest  output  1; memWE  output  1; memDataOut  output  BUS_WIDTH; memByteEnable  output  BUS_WIDTH/8; memDataIn  input  BUS_WIDTH; memBusy  input  1.

Function
REQ-013 SHALL compute effective address = base + sign-extended imm, modulo 2^ADDR_WIDTH.
REQ-014 SHALL use FSM states IDLE, REQ, WAIT, DONE; start accepted only in IDLE; start in other states ignored.
REQ-015 SHALL on accepted start latch address, op, writeEnable, storeData and move to REQ on next edge.
REQ-016 SHALL in REQ drive memRequest=1, memAddr aligned to BUS_WIDTH/8 bytes, memWE=writeEnable, then go to WAIT.
REQ-017 SHALL hold memRequest, memAddr, memWE, memDataOut, memByteEnable stable in WAIT; memBusy sampled only in WAIT.
REQ-018 SHALL in WAIT with memBusy=0 capture memDataIn, deassert memRequest and memWE, go to DONE.
REQ-019 SHALL in DONE pulse done=1 for exactly one cycle, then return to IDLE; minimum latency start-to-done 3 cycles.
REQ-020 SHALL for stores replicate the low 1/2/4/8 bytes of storeData into the addressed lane(s) and set only those memByteEnable bits.
REQ-021 SHALL for loads select addressed lane(s), sign-extend (op[2]=0) or zero-extend (op[2]=1) to BUS_WIDTH; stores leave loadData unchanged.
REQ-022 SHALL treat size 3 with BUS_WIDTH=32 as illegal: error pulse one cycle after start, no memory request, back to IDLE.
REQ-023 SHALL hold loadData at its last value outside DONE.

Reset
REQ-024 SHALL on reset asynchronously enter IDLE with busy, done, error, memRequest, memWE=0, memByteEnable=0, memAddr, memDataOut, loadData=0.
REQ-025 SHALL on reset mid-transaction drop memRequest immediately and produce no done or error pulse.

Configuration
REQ-026 SHALL with LSU_MISALIGN_TRAP_EN defined treat address not aligned to access size as fault: error pulse one cycle after start, no memory request, FSM to IDLE.
REQ-027 SHALL without LSU_MISALIGN_TRAP_EN force the low log2(size) address bits to zero and perform the access normally; error never set except per REQ-022.

Verification
REQ-028 SHALL check word load: base=0x100, imm=0x0004, memDataIn=0xDEADBEEF, memBusy 0 -> memAddr=0x104, done on cycle 3, loadData=0xDEADBEEF.
REQ-029 SHALL check signed byte load: address 0x203, lane byte 0x80 -> loadData=0xFFFFFF80; same with op[2]=1 -> 0x00000080.
REQ-030 SHALL check byte store: address 0x102, storeData=0x123456AB -> memDataOut lanes 0xABABABAB, memByteEnable=4'b0100, memWE=1.
REQ-031 SHALL check wait states: memBusy high 5 cycles in WAIT -> outputs stable, done exactly once after memBusy falls; start during busy ignored.
REQ-032 SHALL check misaligned word at 0x102: with LSU_MISALIGN_TRAP_EN error pulse, memRequest never asserted; without it memAddr=0x100, done.
REQ-033 SHALL check reset asserted in WAIT -> memRequest low same cycle, busy=0, no done; next start completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request and memory-side signal bundle for load_store_unit.
// slave is the LSU view; master is the view of whoever issues requests and serves memory.
interface load_store_unit_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    start;
    logic [2:0]              op;
    logic                    writeEnable;
    logic [ADDR_WIDTH-1:0]   base;
    logic [15:0]             imm;
    logic [BUS_WIDTH-1:0]    storeData;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic [BUS_WIDTH-1:0]    loadData;
    logic [ADDR_WIDTH-1:0]   memAddr;
    logic                    memRequest;
    logic                    memWE;
    logic [BUS_WIDTH-1:0]    memDataOut;
    logic [BUS_WIDTH/8-1:0]  memByteEnable;
    logic [BUS_WIDTH-1:0]    memDataIn;
    logic                    memBusy;

    modport slave (
        input  start, op, writeEnable, base, imm, storeData, memDataIn, memBusy,
        output busy, done, error, loadData, memAddr, memRequest, memWE, memDataOut, memByteEnable
    );

    modport master (
        output start, op, writeEnable, base, imm, storeData, memDataIn, memBusy,
        input  busy, done, error, loadData, memAddr, memRequest, memWE, memDataOut, memByteEnable
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: base+imm addressing, lane steering and extension, IDLE/REQ/WAIT/DONE memory handshake.
// Define LSU_MISALIGN_TRAP_EN to fault on misaligned accesses instead of aligning them down.
module load_store_unit #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    localparam int NBYTES = BUS_WIDTH / 8;
    localparam int OFFW   = $clog2(NBYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [ADDR_WIDTH-1:0] w_ea;
    logic [ADDR_WIDTH-1:0] w_size_mask;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [15:0]           w_len_mask;
    logic                  w_illegal_size;
    logic                  w_misaligned;
    logic                  w_fault;
    logic                  w_accept;
    logic                  w_complete;
    logic [OFFW-1:0]       w_offset;
    logic [BUS_WIDTH-1:0]  w_store_data;
    logic [NBYTES-1:0]     w_byte_en;
    logic [BUS_WIDTH-1:0]  w_shifted;
    logic [BUS_WIDTH-1:0]  w_load_ext;
    logic                  w_fill;

    logic [1:0]            r_size;
    logic                  r_zext;
    logic [OFFW-1:0]       r_offset;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [BUS_WIDTH-1:0]  r_mem_dout;
    logic [NBYTES-1:0]     r_mem_be;
    logic [BUS_WIDTH-1:0]  r_load_data;

    assign w_ea           = bus.base + ADDR_WIDTH'($signed(bus.imm));
    assign w_size_mask    = ADDR_WIDTH'((4'd1 << bus.op[1:0]) - 4'd1);
    assign w_len_mask     = (16'd1 << (4'd1 << bus.op[1:0])) - 16'd1;
    assign w_illegal_size = (bus.op[1:0] == 2'd3) && (BUS_WIDTH == 32);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misaligned = |(w_ea & w_size_mask);
    assign w_addr       = w_ea;
`else
    assign w_misaligned = 1'b0;
    assign w_addr       = w_ea & ~w_size_mask;
`endif

    assign w_fault    = w_illegal_size | w_misaligned;
    assign w_accept   = (r_state == S_IDLE) && bus.start;
    assign w_complete = (r_state == S_WAIT) && !bus.memBusy;
    assign w_offset   = w_addr[OFFW-1:0];
    assign w_byte_en  = NBYTES'(w_len_mask << w_offset);

    // Replicate the low bytes of the store operand across every lane of the bus.
    always_comb begin
        w_store_data = '0;
        case (bus.op[1:0])
            2'd0:    w_store_data = {NBYTES{bus.storeData[7:0]}};
            2'd1:    w_store_data = {(NBYTES/2){bus.storeData[15:0]}};
            2'd2:    w_store_data = {(NBYTES/4){bus.storeData[31:0]}};
            default: w_store_data = bus.storeData;
        endcase
    end

    assign w_shifted = bus.memDataIn >> {r_offset, 3'b000};

    // Right-align the addressed lane(s) and fill the upper bits with sign or zero.
    always_comb begin
        w_fill     = 1'b0;
        w_load_ext = w_shifted;
        case (r_size)
            2'd0:    w_fill = ~r_zext & w_shifted[7];
            2'd1:    w_fill = ~r_zext & w_shifted[15];
            2'd2:    w_fill = ~r_zext & w_shifted[31];
            default: w_fill = 1'b0;
        endcase
        for (int i = 0; i < BUS_WIDTH; i++) begin
            if (i >= (8 << r_size)) begin
                w_load_ext[i] = w_fill;
            end else begin
                w_load_ext[i] = w_shifted[i];
            end
        end
    end

    // Next-state logic; faulting requests never leave IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !w_fault) begin
                    w_next_state = S_REQ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REQ:  w_next_state = S_WAIT;
            S_WAIT: begin
                if (!bus.memBusy) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered outputs; the memory request is launched at accept and held until WAIT completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_dout  <= '0;
            r_mem_be    <= '0;
            r_load_data <= '0;
            r_size      <= 2'd0;
            r_zext      <= 1'b0;
            r_offset    <= '0;
        end else begin
            r_busy  <= (w_next_state != S_IDLE);
            r_done  <= w_complete;
            r_error <= w_accept && w_fault;
            if (w_accept && !w_fault) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= bus.writeEnable;
                r_mem_addr <= w_addr & ~ADDR_WIDTH'(NBYTES - 1);
                r_mem_dout <= bus.writeEnable ? w_store_data : '0;
                r_mem_be   <= bus.writeEnable ? w_byte_en : '0;
                r_size     <= bus.op[1:0];
                r_zext     <= bus.op[2];
                r_offset   <= w_offset;
            end else if (w_complete) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (!r_mem_we) begin
                    r_load_data <= w_load_ext;
                end else begin
                    r_load_data <= r_load_data;
                end
            end else begin
                r_mem_req <= r_mem_req;
            end
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.error         = r_error;
    assign bus.loadData      = r_load_data;
    assign bus.memAddr       = r_mem_addr;
    assign bus.memRequest    = r_mem_req;
    assign bus.memWE         = r_mem_we;
    assign bus.memDataOut    = r_mem_dout;
    assign bus.memByteEnable = r_mem_be;
endmodule
